// File: rtl/cpu_pkg.sv
// Shared processor constants and the register-dump FSM state encoding.
`timescale 1ns/1ps
package cpu_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SEND_LO,
    ST_SEND_HI,
    ST_SEND_SUM
  } dump_state_t;

endpackage

// File: rtl/reg_dump_unit.sv
// Debug readout engine: stalls the CPU, reads the register file in pairs and
// streams every register plus a mod-2^DATA_W checksum over a valid/ready channel.
`timescale 1ns/1ps
module reg_dump_unit #(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] RF_OUT1ADDRESS,
  output logic [ADDR_W-1:0] RF_OUT2ADDRESS,
  input  logic [DATA_W-1:0] RF_OUT1,
  input  logic [DATA_W-1:0] RF_OUT2,
  output logic [DATA_W-1:0] TX_DATA,
  output logic [ADDR_W-1:0] TX_ADDR,
  output logic              TX_LAST,
  output logic              TX_VALID,
  input  logic              TX_READY
);

  import cpu_pkg::*;

  localparam int PAIR_W = ADDR_W - 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_REGS / 2 - 1);

  dump_state_t       state_q, state_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] lo_buf_q, lo_buf_d;
  logic [DATA_W-1:0] hi_buf_q, hi_buf_d;
  logic              done_q, done_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      pair_q   <= '0;
      sum_q    <= '0;
      lo_buf_q <= '0;
      hi_buf_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pair_q   <= pair_d;
      sum_q    <= sum_d;
      lo_buf_q <= lo_buf_d;
      hi_buf_q <= hi_buf_d;
      done_q   <= done_d;
    end
  end

  // TX_VALID is a pure state decode, so TX_READY only steers the next state.
  always_comb begin
    state_d  = state_q;
    pair_d   = pair_q;
    sum_d    = sum_q;
    lo_buf_d = lo_buf_q;
    hi_buf_d = hi_buf_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          pair_d  = '0;
          sum_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        lo_buf_d = RF_OUT1;
        hi_buf_d = RF_OUT2;
        state_d  = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (TX_READY) begin
          sum_d   = sum_q + lo_buf_q;
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (TX_READY) begin
          sum_d = sum_q + hi_buf_q;
          if (pair_q == LAST_PAIR) begin
            state_d = ST_SEND_SUM;
          end else begin
            pair_d  = pair_q + 1'b1;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SEND_SUM: begin
        if (TX_READY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read addresses stay parked on the current pair for the whole dump.
  always_comb begin
    BUSY           = (state_q != ST_IDLE);
    DONE           = done_q;
    RF_OUT1ADDRESS = '0;
    RF_OUT2ADDRESS = '0;
    TX_VALID       = 1'b0;
    TX_LAST        = 1'b0;
    TX_DATA        = '0;
    TX_ADDR        = '0;
    if (state_q != ST_IDLE) begin
      RF_OUT1ADDRESS = {pair_q, 1'b0};
      RF_OUT2ADDRESS = {pair_q, 1'b1};
    end
    case (state_q)
      ST_SEND_LO: begin
        TX_VALID = 1'b1;
        TX_DATA  = lo_buf_q;
        TX_ADDR  = {pair_q, 1'b0};
      end
      ST_SEND_HI: begin
        TX_VALID = 1'b1;
        TX_DATA  = hi_buf_q;
        TX_ADDR  = {pair_q, 1'b1};
      end
      ST_SEND_SUM: begin
        TX_VALID = 1'b1;
        TX_LAST  = 1'b1;
        TX_DATA  = sum_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit: table of dump scenarios scored
// against an expected-beat queue, plus reset and abort sequences.
`timescale 1ns/1ps
module tb_reg_dump_unit;

  import cpu_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    logic [7:0][7:0] regs;
    logic [7:0]      exp_sum;
    int              exp_done_cycle;
    int              mode;
  } vec_t;

  localparam int MODE_PLAIN     = 0;
  localparam int MODE_BACKPRESS = 1;
  localparam int MODE_MID_START = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              tx_ready = 1'b1;
  logic              busy, done, tx_last, tx_valid;
  logic [ADDR_W-1:0] rf_out1address, rf_out2address, tx_addr;
  logic [DATA_W-1:0] rf_out1, rf_out2, tx_data;
  logic [DATA_W-1:0] rf_mem [8];

  int    checks = 0;
  int    failures = 0;
  int    edge_cnt = 0;
  int    base_edge = 0;
  int    done_count = 0;
  int    done_cycle = 0;
  int    busy_count = 0;
  int    beats_seen = 0;
  beat_t exp_q[$];
  beat_t mon_e;

  reg_dump_unit #(.NUM_REGS(8), .DATA_W(8), .ADDR_W(3)) dut (
    .CLK            (clk),
    .RESET          (rst),
    .START          (start),
    .BUSY           (busy),
    .DONE           (done),
    .RF_OUT1ADDRESS (rf_out1address),
    .RF_OUT2ADDRESS (rf_out2address),
    .RF_OUT1        (rf_out1),
    .RF_OUT2        (rf_out2),
    .TX_DATA        (tx_data),
    .TX_ADDR        (tx_addr),
    .TX_LAST        (tx_last),
    .TX_VALID       (tx_valid),
    .TX_READY       (tx_ready)
  );

  // Register file model: combinational read ports.
  assign rf_out1 = rf_mem[rf_out1address];
  assign rf_out2 = rf_mem[rf_out2address];

  initial forever #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {11'b0, busy, done, tx_valid, tx_last, tx_data, tx_addr, rf_out1address, rf_out2address};
  endfunction

  // Scoreboard monitor: a beat seen valid&&ready at the falling edge is accepted at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL beat_extra actual addr=%0h data=%0h required=no beat", tx_addr, tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("beat_addr", 32'(tx_addr), 32'(mon_e.addr));
          checkOutput("beat_data", 32'(tx_data), 32'(mon_e.data));
          checkOutput("beat_last", 32'(tx_last), 32'(mon_e.last));
        end
        beats_seen++;
      end
      if (done) begin
        done_count++;
        done_cycle = edge_cnt - base_edge + 1;
      end
      if (busy) busy_count++;
    end
  end

  task automatic start_dump();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 base_edge = edge_cnt;
    start = 1'b0;
  endtask

  task automatic load_and_expect(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = v.regs[i];
      exp_q.push_back('{addr: 3'(i), data: v.regs[i], last: 1'b0});
    end
    exp_q.push_back('{addr: 3'd0, data: v.exp_sum, last: 1'b1});
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int  d0, b0, s0;
    bit  found;
    d0 = done_count;
    b0 = busy_count;
    s0 = beats_seen;
    load_and_expect(v);
    start_dump();
    if (v.mode == MODE_MID_START) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    if (v.mode == MODE_BACKPRESS) begin
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        #1;
        if (tx_valid && tx_addr == 3'd2) begin
          found = 1'b1;
          break;
        end
      end
      checkOutput({tag, "_reach_addr2"}, 32'(found), 32'd1);
      @(posedge clk);
      #1 tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checkOutput({tag, "_stall_valid"}, 32'(tx_valid), 32'd1);
        checkOutput({tag, "_stall_addr"}, 32'(tx_addr), 32'd3);
        checkOutput({tag, "_stall_data"}, 32'(tx_data), 32'(v.regs[3]));
      end
      @(posedge clk);
      #1 tx_ready = 1'b1;
    end
    for (int i = 0; i < 200 && done_count == d0; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput({tag, "_done_seen"}, 32'(done_count - d0), 32'd1);
    checkOutput({tag, "_done_cycle"}, 32'(done_cycle), 32'(v.exp_done_cycle));
    checkOutput({tag, "_busy_cycles"}, 32'(busy_count - b0), 32'(v.exp_done_cycle - 1));
    repeat (20) @(negedge clk);
    #1;
    checkOutput({tag, "_one_done"}, 32'(done_count - d0), 32'd1);
    checkOutput({tag, "_beat_count"}, 32'(beats_seen - s0), 32'd9);
    checkOutput({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_idle_outputs"}, outs_vec(), 32'd0);
  endtask

  initial begin
    vec_t tbl[5];
    int   v_cnt;
    int   d0;
    bit   found;

    tbl[0] = '{regs: {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10},
               exp_sum: 8'h9C, exp_done_cycle: 14, mode: MODE_PLAIN};
    tbl[1] = '{regs: {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10},
               exp_sum: 8'h9C, exp_done_cycle: 17, mode: MODE_BACKPRESS};
    tbl[2] = '{regs: {8{8'hFF}}, exp_sum: 8'hF8, exp_done_cycle: 14, mode: MODE_PLAIN};
    tbl[3] = '{regs: {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10},
               exp_sum: 8'h9C, exp_done_cycle: 14, mode: MODE_MID_START};
    tbl[4] = '{regs: {8'hCC, 8'h33, 8'h55, 8'hAA, 8'h00, 8'h7F, 8'h80, 8'h01},
               exp_sum: 8'hFE, exp_done_cycle: 14, mode: MODE_PLAIN};

    for (int i = 0; i < 8; i++) rf_mem[i] = '0;

    #2 rst = 1'b1;
    #3 checkOutput("reset_outputs", outs_vec(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    v_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid || busy) v_cnt++;
    end
    checkOutput("idle_no_valid", 32'(v_cnt), 32'd0);
    checkOutput("idle_outputs", outs_vec(), 32'd0);

    for (int t = 0; t < 5; t++) applyStimulus(tbl[t], $sformatf("vec%0d", t));

    // Abort after the addr 2 handshake, then confirm a clean restart.
    d0 = done_count;
    load_and_expect(tbl[0]);
    start_dump();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (tx_valid && tx_ready && tx_addr == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort_reach_addr2", 32'(found), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("abort_outputs", outs_vec(), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("abort_no_done", 32'(done_count - d0), 32'd0);
    checkOutput("abort_idle", outs_vec(), 32'd0);
    applyStimulus(tbl[0], "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/reg_dump_unit.md
# reg_dump_unit

Debug readout engine for the 8-bit single-cycle processor. It sits beside `reg_file` on its two read ports. On a `START` command it stalls the CPU and reads all eight registers in pairs. It then streams them out one byte per beat over a valid/ready channel, followed by a mod-256 checksum beat. It is the reader/consumer counterpart to the datapath that writes the register file, used by the test harness and the debug UART bridge.

## Interface
Parameters:
- `NUM_REGS`, 8: registers dumped; must be even.
- `DATA_W`, 8: register and stream data width.
- `ADDR_W`, 3: register address width.

Ports:
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RESET` in 1: asynchronous, active-high; clears all state immediately.
- `START` in 1: dump request, sampled only in IDLE.
- `BUSY` out 1: high whenever state ≠ IDLE; drives the CPU PC/write-enable stall.
- `DONE` out 1: one-cycle pulse after the checksum beat is accepted.
- `RF_OUT1ADDRESS` out `ADDR_W`: to `reg_file` OUT1ADDRESS.
- `RF_OUT2ADDRESS` out `ADDR_W`: to `reg_file` OUT2ADDRESS.
- `RF_OUT1` in `DATA_W`: from `reg_file` OUT1.
- `RF_OUT2` in `DATA_W`: from `reg_file` OUT2.
- `TX_DATA` out `DATA_W`: stream byte.
- `TX_ADDR` out `ADDR_W`: register index of the current beat; 0 on the checksum beat.
- `TX_LAST` out 1: high only on the checksum beat.
- `TX_VALID` out 1: beat available.
- `TX_READY` in 1: consumer accepts; a handshake occurs when `TX_VALID && TX_READY` at a rising edge.

## Operation
- FSM states: IDLE, SETTLE, SEND_LO, SEND_HI, SEND_SUM. `pair` counter runs 0..NUM_REGS/2−1.
- IDLE:
  - `RF_OUT1ADDRESS` and `RF_OUT2ADDRESS` are 0.
  - On `START`=1: clear `pair` and `sum`, then go to SETTLE.
- SETTLE:
  - Drive `RF_OUT1ADDRESS`={pair,0} and `RF_OUT2ADDRESS`={pair,1} for one full cycle, covering the `reg_file` read delay.
  - At the closing edge, capture `RF_OUT1` into `lo_buf` and `RF_OUT2` into `hi_buf`, then go to SEND_LO.
- SEND_LO:
  - `TX_VALID`=1, `TX_DATA`=`lo_buf`, `TX_ADDR`=2·pair.
  - On handshake: `sum += lo_buf`, go to SEND_HI.
- SEND_HI:
  - `TX_VALID`=1, `TX_DATA`=`hi_buf`, `TX_ADDR`=2·pair+1.
  - On handshake: `sum += hi_buf`.
  - If pair = last, go to SEND_SUM; otherwise increment `pair` and go to SETTLE.
- SEND_SUM:
  - `TX_VALID`=1, `TX_DATA`=`sum`, `TX_ADDR`=0, `TX_LAST`=1.
  - On handshake: go to IDLE and pulse `DONE`.
- Arithmetic: `sum` is `DATA_W` bits and wraps modulo 2^DATA_W. No carry is kept.
- Addresses and data are held while `BUSY`, and `WRITE` to `reg_file` is suppressed by the stall. Captured buffers are therefore coherent.

## Timing
- Reset values:
  - State IDLE; `BUSY`, `DONE`, `TX_VALID`, `TX_LAST` = 0.
  - `TX_DATA`, `TX_ADDR`, `RF_OUT*ADDRESS`, `sum`, `pair`, `lo_buf`, `hi_buf` = 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `TX_READY` to any output.
- Handshake rule: while `TX_VALID`=1 and `TX_READY`=0, `TX_DATA`, `TX_ADDR` and `TX_LAST` are held stable. `TX_VALID` never drops without a handshake, except on `RESET`.
- Latency with `TX_READY` tied high, `START` sampled at edge 0:
  - `BUSY` rises after edge 0.
  - First beat is valid in cycle 2; pair p SEND_LO is in cycle 2+3p.
  - Checksum beat is in cycle 13; `DONE` is high in cycle 14.
  - Minimum dump is 14 cycles.
- `START` while `BUSY`: ignored; no queuing.
- `START` held high through `DONE`: a new dump begins in the `DONE` cycle, since state is IDLE.
- `RESET` mid-dump: immediate abort to reset values. No `DONE` pulse and no partial checksum. The next `START` restarts from register 0.

## Structure
- Shared package `cpu_pkg` holds:
  - `DATA_W`/`ADDR_W` constants, shared with `reg_file`.
  - The `dump_state_t` enum.
- No sub-module is required. The FSM, counter, buffers and accumulator fit in one module.

## Test plan
- Preload r0..r7 = 0x10..0x17, `TX_READY`=1, pulse `START`:
  - Beats (addr,data) (0,0x10)…(7,0x17), then checksum 0x9C with `TX_LAST`.
  - `DONE` in cycle 14; `BUSY` high over cycles 1–13.
- Backpressure: same preload, hold `TX_READY`=0 for 3 cycles when addr 3 is valid.
  - `TX_DATA`=0x13, `TX_ADDR`=3 held stable throughout; no beat lost or duplicated.
- Wrap-around: all registers 0xFF → checksum 0xF8.
- Reset mid-dump: assert `RESET` asynchronously after the addr 2 handshake.
  - All outputs zero immediately; no `DONE`.
  - A subsequent `START` streams from addr 0 with a fresh checksum.
- `START` pulsed during cycle 5 of an active dump → ignored; exactly 9 beats and one `DONE`.
- Power-up/reset check: every output equals its reset value. `TX_VALID` stays 0 with `START`=0 for 20 cycles.
